// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_t   : divider control states (IDLE / CALC / FIN)
//   DIV_WIDTH : default operand/result width
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int unsigned DIV_WIDTH = 4;

endpackage

// File: rtl/seq_divider_sub.sv
// Ripple-borrow subtractor used for the trial subtraction of each division step.
// Ports:
//   a, b   : N-bit unsigned minuend / subtrahend
//   diff   : N-bit difference a - b (modulo 2^N)
//   borrow : 1 when a < b
module seq_divider_sub #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic bc;

  always_comb begin
    diff = '0;
    bc   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      diff[i] = a[i] ^ b[i] ^ bc;
      bc      = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bc);
    end
    borrow = bc;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   start    : request pulse, accepted when idle
//   dividend : WIDTH-bit numerator
//   divisor  : WIDTH-bit denominator
//   q, r     : quotient / remainder, held until replaced by a later result
//   busy     : high while the division steps run
//   done     : one-cycle pulse marking valid q/r
//   dz       : divide-by-zero flag, valid with done
// Build option: define SEQ_DIVIDER_DZ_DETECT_EN to detect divisor=0 at
// acceptance and finish immediately with dz=1; otherwise dz is tied low and a
// zero divisor runs the normal algorithm (q = all ones, r = dividend).
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;       // partial remainder
  logic [WIDTH-1:0] quo;       // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dsr;       // latched divisor
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             go_fin_now;
  logic             unused_diff_msb;

  assign trial = {rem, quo[WIDTH-1]};

  seq_divider_sub #(.N(WIDTH + 1)) u_sub (
    .a      (trial),
    .b      ({1'b0, dsr}),
    .diff   (diff),
    .borrow (borrow)
  );

  // Kept differences are always below the divisor, so the MSB carries nothing.
  assign unused_diff_msb = diff[WIDTH];
  assign rem_step        = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
  assign quo_step        = {quo[WIDTH-2:0], ~borrow};

`ifdef SEQ_DIVIDER_DZ_DETECT_EN
  assign go_fin_now = (divisor == '0);
`else
  assign go_fin_now = 1'b0;
`endif

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = go_fin_now ? FIN : CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_next = FIN;
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // q/r are loaded on the edge entering FIN so they are already valid while
  // done is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dsr <= '0;
      q   <= '0;
      r   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dsr <= divisor;
          quo <= dividend;
          rem <= '0;
          cnt <= CW'(WIDTH - 1);
          if (go_fin_now) begin
            q <= '1;
            r <= dividend;
          end
        end
        CALC: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            q <= quo_step;
            r <= rem_step;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_DIVIDER_DZ_DETECT_EN
  logic dz_q;
  always_ff @(posedge clk) begin
    if (reset)                                dz_q <= 1'b0;
    else if ((state == IDLE) && start) dz_q <= go_fin_now;
  end
  assign dz = dz_q;
`else
  assign dz = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): directed cases, ignored start,
// mid-operation reset, and a shuffled sweep of all operand pairs.
module tb_seq_divider;

  localparam int unsigned W = 4;

`ifdef SEQ_DIVIDER_DZ_DETECT_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] dividend, divisor, q, r;
  logic         busy, done, dz;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .q        (q),
    .r        (r),
    .busy     (busy),
    .done     (done),
    .dz       (dz)
  );

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           acc;
    int           lat;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain integer division; zero divisor gives all ones / dividend.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    if (b == 0) begin
      e.q   = '1;
      e.r   = W'(a);
      e.dz  = DZ_EN;
      e.lat = DZ_EN ? 0 : W;
    end else begin
      e.q   = W'(a / b);
      e.r   = W'(a % b);
      e.dz  = 1'b0;
      e.lat = W;
    end
    e.acc = 0;
    return e;
  endfunction

  // Monitor: every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", int'(done), 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("q", int'(q), int'(e.q));
        check("r", int'(r), int'(e.r));
        check("dz", int'(dz), int'(e.dz));
        check("latency", cyc - e.acc, e.lat);
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  task automatic launch(input int a, input int b, output exp_t e);
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk);
    #1;
    e     = model(a, b);
    e.acc = cyc;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3 * W + 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  task automatic finish_op(input exp_t e);
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    for (int k = 0; k < e.lat; k++) begin
      check("busy_calc", int'(busy), 1);
      if (k < e.lat - 1) @(negedge clk);
    end
    wait_drain();
    @(negedge clk);
    check("hold_q", int'(q), int'(e.q));
    check("hold_r", int'(r), int'(e.r));
  endtask

  task automatic run_op(input int a, input int b);
    exp_t e;
    launch(a, b, e);
    finish_op(e);
  endtask

  int perm[256];

  initial begin
    exp_t e;
    reset    = 1'b1;
    start    = 1'b1;
    dividend = 4'd13;
    divisor  = 4'd3;
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_q", int'(q), 0);
    check("rst_r", int'(r), 0);
    check("rst_dz", int'(dz), 0);
    start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("start_during_reset_ignored", int'(busy), 0);

    run_op(13, 3);
    run_op(15, 1);
    run_op(2, 7);
    run_op(15, 15);
    run_op(9, 0);

    // Second start while busy must be ignored.
    launch(12, 5, e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd6;
    divisor  = 4'd2;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (W + 3) @(negedge clk);
    check("ignored_start_q", int'(q), 2);
    check("ignored_start_r", int'(r), 2);

    // Reset during the second CALC cycle discards the operation.
    @(negedge clk);
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_q", int'(q), 0);
    check("midrst_r", int'(r), 0);
    check("midrst_dz", int'(dz), 0);
    reset = 1'b0;
    repeat (W + 3) @(negedge clk);
    run_op(14, 4);

    // All operand pairs in shuffled order.
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j       = int'($urandom_range(i, 0));
      t       = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 256; i++) run_op(perm[i] / 16, perm[i] % 16);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
